usfft_bitstream_decoder: RTL and testbench
==========================================

Name: usfft_bitstream_decoder

Overview:
- Receive-side companion to the 4-point unary/stochastic FFT.
- Consumes the eight FFT output bitstreams (C real/imag 0/1, D real/imag 0/1) over a fixed window of 2^BITWIDTH cycles.
- Counts the ones on each stream and presents eight binary results with a valid/ready handshake.
- Sits between the FFT core and any binary-domain consumer (register file, bus bridge, scoreboard).

Parameters:
BITWIDTH, 8, result width; observation window = 2^BITWIDTH cycles.

Ports:
iClk  input  1  clock; all logic rising-edge.
iRst  input  1  synchronous, active-high reset.
iClr  input  1  synchronous abort: drop the current window and results, return to IDLE.
iStart  input  1  request a new decode window.
iReady  input  1  consumer accepts the results.
iCReal0, iCImg0, iCReal1, iCImg1  input  1 each  FFT output bitstreams, C pair.
iDReal0, iDImg0, iDReal1, iDImg1  input  1 each  FFT output bitstreams, D pair.
oBusy  output  1  high while in ACC.
oValid  output  1  results valid.
oCReal0Bin, oCImg0Bin, oCReal1Bin, oCImg1Bin  output  BITWIDTH each  decoded C results.
oDReal0Bin, oDImg0Bin, oDReal1Bin, oDImg1Bin  output  BITWIDTH each  decoded D results.

Behaviour:
- Reset (iRst=1): FSM goes to IDLE. All eight counters, the sample counter, all result registers, oValid and oBusy go to 0. iRst has priority over iClr and all other inputs.
- States: IDLE, ACC, HOLD.
- IDLE
  - iStart=1: clear the eight ones-counters and the sample counter; go to ACC.
  - Otherwise stay in IDLE.
- ACC
  - oBusy=1.
  - Each cycle, every ones-counter (BITWIDTH+1 bits) increments if its input bit is 1; the sample counter increments.
  - On the 2^BITWIDTH-th sample cycle (sample counter = 2^BITWIDTH-1), that cycle's bits are included. Then load the result registers from the counters and go to HOLD.
  - iStart in ACC is ignored.
- Sample timing: iStart accepted at cycle t → samples taken on cycles t+1 .. t+2^BITWIDTH → oValid=1 from cycle t+2^BITWIDTH+1.
- Saturation: count = 2^BITWIDTH (all ones) saturates to 2^BITWIDTH-1. All other counts pass through unchanged.
- HOLD
  - oValid=1. Results and oValid stay stable while iReady=0, regardless of input bitstreams.
  - iReady=1: handshake completes. oValid=0 next cycle; go to IDLE.
  - iReady=1 and iStart=1 in the same cycle: go directly to ACC with counters cleared, no idle bubble.
  - iStart without iReady is ignored.
- Result registers keep their last values after the handshake until overwritten by the next window; oValid qualifies them.
- iClr (any state, iRst=0): next cycle IDLE, oValid=0, oBusy=0, counters and results cleared. iClr beats iStart in the same cycle.
- Reset or iClr in mid-window discards the partial window; no results are produced for it.

Optional Feature:
- Macro: USFFT_DEC_BIPOLAR_EN
- Defined: results are bipolar two's complement. Each output = saturated count − 2^(BITWIDTH-1), implemented as an MSB inversion of the saturated count.
  - All-ones stream → 2^(BITWIDTH-1)-1.
  - All-zeros stream → −2^(BITWIDTH-1).
  - 50% density stream → 0.
- Undefined: unsigned unipolar counts as described in Behaviour.
- Reset value of the result registers is 0 in both modes.

Test Plan:
All scenarios use BITWIDTH=4 (window 16 cycles).
- Reset: hold iRst 3 cycles with random inputs → oValid=0, oBusy=0, all eight results 0x0; iStart during reset is ignored.
- Basic decode: iStart at t; iCReal0=1 constant, iCImg0=0, iCReal1 toggling 1010…, iDImg1 with 3 ones in the window, others 0 → oBusy high t+1..t+16, oValid at t+17, oCReal0Bin=0xF (saturated), oCImg0Bin=0x0, oCReal1Bin=0x8, oDImg1Bin=0x3.
- Backpressure: keep iReady=0 for 5 cycles after oValid while toggling all inputs → outputs unchanged; iReady=1 → oValid=0 next cycle, FSM in IDLE; a second iStart decodes fresh values.
- Back-to-back: iReady=1 and iStart=1 in the same HOLD cycle → oValid=0 and oBusy=1 next cycle; new results are valid 16 cycles later and reflect only new-window bits.
- Abort: iClr at sample 7 of a window → IDLE next cycle, no oValid; iClr together with iStart in IDLE → stays IDLE.
- Bipolar (USFFT_DEC_BIPOLAR_EN defined): all-ones → 0x7, all-zeros → 0x8, alternating → 0x0, 12 ones → 0x4.

Source files
------------

// File: rtl/usfft_bitstream_decoder.sv
// Counts ones on the eight 4-point unary FFT output bitstreams over a 2^BITWIDTH window; valid/ready result hand-off.
// Optional macro USFFT_DEC_BIPOLAR_EN: results become bipolar two's complement (saturated count MSB inverted).
module usfft_bitstream_decoder #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iReady,
  input  logic                iCReal0,
  input  logic                iCImg0,
  input  logic                iCReal1,
  input  logic                iCImg1,
  input  logic                iDReal0,
  input  logic                iDImg0,
  input  logic                iDReal1,
  input  logic                iDImg1,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oCReal0Bin,
  output logic [BITWIDTH-1:0] oCImg0Bin,
  output logic [BITWIDTH-1:0] oCReal1Bin,
  output logic [BITWIDTH-1:0] oCImg1Bin,
  output logic [BITWIDTH-1:0] oDReal0Bin,
  output logic [BITWIDTH-1:0] oDImg0Bin,
  output logic [BITWIDTH-1:0] oDReal1Bin,
  output logic [BITWIDTH-1:0] oDImg1Bin
);

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = BITWIDTH + 1;
  localparam logic [BITWIDTH-1:0] SAMP_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [NCH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [BITWIDTH-1:0]             samp_q, samp_d;
  logic [NCH-1:0][BITWIDTH-1:0]    res_q, res_d;
  logic                            valid_q, valid_d;
  logic                            busy_q, busy_d;
  logic [NCH-1:0]                  bits_c;

  assign bits_c = {iDImg1, iDReal1, iDImg0, iDReal0, iCImg1, iCReal1, iCImg0, iCReal0};

  // A full-window count of 2^BITWIDTH does not fit the result; clamp it to all ones.
  function automatic logic [BITWIDTH-1:0] to_result(input logic [CW-1:0] cnt);
    logic [BITWIDTH-1:0] s;
    s = cnt[BITWIDTH] ? '1 : cnt[BITWIDTH-1:0];
`ifdef USFFT_DEC_BIPOLAR_EN
    s[BITWIDTH-1] = ~s[BITWIDTH-1];
`endif
    return s;
  endfunction

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      samp_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          cnt_d   = '0;
          samp_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        for (int i = 0; i < NCH; i++) begin
          cnt_d[i] = cnt_q[i] + CW'(bits_c[i]);
        end
        samp_d = samp_q + BITWIDTH'(1);
        // Last sample of the window is folded in before the results are captured.
        if (samp_q == SAMP_LAST) begin
          for (int i = 0; i < NCH; i++) begin
            res_d[i] = to_result(cnt_d[i]);
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (iReady) begin
          if (iStart) begin
            cnt_d   = '0;
            samp_d  = '0;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (iClr) begin
      state_d = IDLE;
      cnt_d   = '0;
      samp_d  = '0;
      res_d   = '0;
    end
    valid_d = (state_d == HOLD);
    busy_d  = (state_d == ACC);
  end

  assign oBusy      = busy_q;
  assign oValid     = valid_q;
  assign oCReal0Bin = res_q[0];
  assign oCImg0Bin  = res_q[1];
  assign oCReal1Bin = res_q[2];
  assign oCImg1Bin  = res_q[3];
  assign oDReal0Bin = res_q[4];
  assign oDImg0Bin  = res_q[5];
  assign oDReal1Bin = res_q[6];
  assign oDImg1Bin  = res_q[7];

endmodule

// File: tb/tb_usfft_bitstream_decoder.sv
// Randomized bench for usfft_bitstream_decoder (BITWIDTH=4) against a window-level ones-counting model.
module tb_usfft_bitstream_decoder;

  localparam int unsigned BW  = 4;
  localparam int          WIN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [7:0]    bits = '0;
  logic          busy, valid;
  logic [BW-1:0] r0, r1, r2, r3, r4, r5, r6, r7;

  int checks = 0;
  int failures = 0;

  // Model: samples still owed to the current window, hold flag, per-channel ones tallies, published results.
  int win_left = 0;
  bit holding  = 0;
  int ones [8];
  int exp_res [8];

  always #5 clk = ~clk;

  usfft_bitstream_decoder #(.BITWIDTH(BW)) dut (
    .iClk(clk), .iRst(rst), .iClr(clr), .iStart(start), .iReady(ready),
    .iCReal0(bits[0]), .iCImg0(bits[1]), .iCReal1(bits[2]), .iCImg1(bits[3]),
    .iDReal0(bits[4]), .iDImg0(bits[5]), .iDReal1(bits[6]), .iDImg1(bits[7]),
    .oBusy(busy), .oValid(valid),
    .oCReal0Bin(r0), .oCImg0Bin(r1), .oCReal1Bin(r2), .oCImg1Bin(r3),
    .oDReal0Bin(r4), .oDImg0Bin(r5), .oDReal1Bin(r6), .oDImg1Bin(r7)
  );

  function automatic int decode(input int n);
    int s;
    s = (n > WIN - 1) ? WIN - 1 : n;
`ifdef USFFT_DEC_BIPOLAR_EN
    s = (s - WIN / 2) & (WIN - 1);
`endif
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst || clr) begin
      win_left = 0;
      holding  = 0;
      foreach (ones[i]) ones[i] = 0;
      foreach (exp_res[i]) exp_res[i] = 0;
    end else if (win_left > 0) begin
      foreach (ones[i]) ones[i] += int'(bits[i]);
      win_left--;
      if (win_left == 0) begin
        foreach (exp_res[i]) exp_res[i] = decode(ones[i]);
        holding = 1;
      end
    end else if (holding && !ready) begin
      holding = 1;
    end else if (start) begin
      holding  = 0;
      win_left = WIN;
      foreach (ones[i]) ones[i] = 0;
    end else begin
      holding = 0;
    end
  endtask

  task automatic compare();
    logic [BW-1:0] act [8];
    act = '{r0, r1, r2, r3, r4, r5, r6, r7};
    chk("busy", int'(busy), (win_left > 0) ? 1 : 0);
    chk("valid", int'(valid), holding ? 1 : 0);
    for (int i = 0; i < 8; i++) chk($sformatf("res%0d", i), int'(act[i]), exp_res[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    rst = 0; clr = 0; start = 0; ready = 0; bits = '0;
  endtask

  // Directed window: ch0 all ones, ch1 zeros, ch2 alternating, ch3 12 ones, ch7 3 ones.
  task automatic directed_window();
    for (int k = 0; k < WIN; k++) begin
      idle_inputs();
      bits[0] = 1'b1;
      bits[2] = (k % 2 == 0);
      bits[3] = (k < 12);
      bits[7] = (k < 3);
      step();
    end
  endtask

  task automatic random_window();
    for (int k = 0; k < WIN; k++) begin
      idle_inputs();
      bits  = 8'($urandom);
      start = 1'($urandom);
      step();
    end
  endtask

  initial begin
    foreach (ones[i]) ones[i] = 0;
    foreach (exp_res[i]) exp_res[i] = 0;

    // Reset with random traffic, including iStart.
    for (int c = 0; c < 3; c++) begin
      rst = 1; clr = 1'($urandom); start = 1; ready = 1'($urandom); bits = 8'($urandom);
      step();
    end
    chk("reset_valid_lit", int'(valid), 0);
    chk("reset_busy_lit", int'(busy), 0);
    chk("reset_res_lit", int'({r0, r1, r2, r3, r4, r5, r6, r7}), 0);

    // Basic decode.
    idle_inputs(); start = 1; step();
    chk("start_busy_lit", int'(busy), 1);
    directed_window();
    chk("decode_valid_lit", int'(valid), 1);
`ifdef USFFT_DEC_BIPOLAR_EN
    chk("bip_ones_lit", int'(r0), 7);
    chk("bip_zeros_lit", int'(r1), 8);
    chk("bip_alt_lit", int'(r2), 0);
    chk("bip_twelve_lit", int'(r3), 4);
`else
    chk("sat_lit", int'(r0), 15);
    chk("zeros_lit", int'(r1), 0);
    chk("alt_lit", int'(r2), 8);
    chk("twelve_lit", int'(r3), 12);
    chk("three_lit", int'(r7), 3);
`endif

    // Backpressure: results hold while ready is low, iStart ignored.
    for (int c = 0; c < 5; c++) begin
      idle_inputs(); bits = 8'($urandom); start = 1'($urandom); step();
    end
    idle_inputs(); ready = 1; step();
    chk("handshake_valid_lit", int'(valid), 0);
    chk("handshake_busy_lit", int'(busy), 0);
    idle_inputs(); start = 1; step();
    random_window();

    // Back-to-back: ready and start together in HOLD.
    idle_inputs(); ready = 1; start = 1; bits = 8'($urandom); step();
    chk("b2b_valid_lit", int'(valid), 0);
    chk("b2b_busy_lit", int'(busy), 1);
    random_window();
    chk("b2b_done_lit", int'(valid), 1);

    // Abort mid-window, then clear beating start in IDLE.
    idle_inputs(); ready = 1; step();
    idle_inputs(); start = 1; step();
    for (int k = 0; k < 7; k++) begin
      idle_inputs(); bits = 8'($urandom); step();
    end
    idle_inputs(); clr = 1; bits = 8'($urandom); step();
    chk("abort_busy_lit", int'(busy), 0);
    idle_inputs(); clr = 1; start = 1; step();
    chk("clr_start_busy_lit", int'(busy), 0);
    for (int k = 0; k < WIN + 2; k++) begin
      idle_inputs(); bits = 8'($urandom); step();
    end
    chk("abort_no_valid_lit", int'(valid), 0);

    // Random soak with per-window stream densities.
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      rst   = ($urandom_range(0, 299) == 0);
      clr   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 8; i++) bits[i] = ($urandom_range(0, 7) < ((c / 64 + i) % 9));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
